mmio_write_capture: RTL and testbench
=====================================

# mmio_write_capture

Synthesizable MMIO write monitor that taps the CPU core's MMIO write port (word address, data, byte mask, write enable) and records qualifying writes into an on-chip FIFO with timestamps. It replaces console-only simulation logging with a reusable block that works in simulation and on FPGA. It sits beside the CPU top level, in parallel with the MMIO decoder, and is drained by a host-side reader over a valid/ready port. Address width, data width, depth, timestamp width and address window are parameters; overflow accounting is built in.

## Interface
- `ADDR_W`, 30: word-address width (byte address = `{addr, 2'b0}`).
- `DATA_W`, 32: data width; multiple of 8; mask width `MASK_W = DATA_W/8`.
- `DEPTH`, 16: FIFO entries; power of two, >= 2.
- `TS_W`, 16: timestamp counter width.
- `WIN_LO`, 0: lowest captured word address (inclusive).
- `WIN_HI`, all ones: highest captured word address (inclusive).

- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `i_mmio_addr`  in  ADDR_W: tapped write word address.
- `i_mmio_data`  in  DATA_W: tapped write data.
- `i_mmio_mask`  in  MASK_W: tapped byte-enable mask.
- `i_mmio_wren`  in  1: tapped write strobe.
- `i_en`  in  1: capture enable.
- `i_clear`  in  1: synchronous flush.
- `o_rec_valid`  out  1: head record present.
- `i_rec_ready`  in  1: reader accepts head record.
- `o_rec_addr` / `o_rec_data` / `o_rec_mask`  out  ADDR_W / DATA_W / MASK_W: head record fields.
- `o_rec_ts`  out  TS_W: timestamp of head record.
- `o_rec_gap`  out  1: one or more writes were dropped immediately before this record.
- `o_count`  out  $clog2(DEPTH)+1: entries held.
- `o_drops`  out  16: dropped-write counter, saturating.

## Operation
- Qualifying write at an edge: `i_mmio_wren && i_en && i_mmio_mask != 0 && WIN_LO <= i_mmio_addr <= WIN_HI`.
- Timestamp: free-running TS_W counter, +1 every cycle, wraps to 0; record stores counter value of the capture edge.
- FIFO is first-word fall-through; pop = `o_rec_valid && i_rec_ready`.
- Push when qualifying and (not full, or full with pop in same cycle). Full with no pop: write dropped, `o_drops` += 1 (saturate at 16'hFFFF), internal sticky gap flag set.
- Stored record takes gap = sticky flag; flag cleared on that store. Drop and store never coincide.
- Empty with pop: impossible (valid=0); simultaneous push and pop when empty: push only.
- `i_clear`: empties FIFO, zeroes `o_drops` and gap flag; timestamp continues; a qualifying write in the clear cycle is discarded (clear wins over push and pop).
- `o_rec_*` fields are don't-care but stable-at-last-value when `o_rec_valid`=0; while valid and not popped, all fields hold.
- Pointers are log2(DEPTH) bits, wrap naturally; full/empty from `o_count`.

## Timing
- Reset (async assert, sync-released by upstream): `o_rec_valid`=0, `o_count`=0, `o_drops`=0, `o_rec_gap`=0, `o_rec_addr/data/mask/ts`=0, timestamp=0, pointers=0, gap flag=0.
- Capture latency: write qualifying at edge N into empty FIFO -> `o_rec_valid`=1 from after edge N.
- Pop at edge M -> next record (or valid=0) visible after edge M; `o_count` updates at same edge.
- Throughput: one push and one pop per cycle sustained.
- Reset mid-operation discards all contents immediately.

## Structure
- Shared header `mmio_defs.vh`: default ADDR_W/DATA_W, record-field width macros, drop-counter width (16).
- Sub-module `sync_fifo` (parametric WIDTH, DEPTH; push/pop/full/empty/count, FWFT). Top packs `{gap, ts, mask, addr, data}` into one word.

## Test plan
- Reset: hold `rst_n`=0 -> all outputs 0; release, write 0x100/0xDEADBEEF/4'b1111 -> record with that data, ts = cycle count since release, gap=0, valid one edge later.
- Filter: WIN_LO=0x40, WIN_HI=0x4F; writes to 0x3F, 0x40, 0x4F, 0x50, plus mask=0 write to 0x41 -> exactly two records (0x40, 0x4F), drops=0.
- Overflow: DEPTH=4, ready=0, 6 writes (data 1..6) -> count=4, drops=2; drain then write 7 -> records 1,2,3,4,7 with gap only on 7.
- Full with simultaneous pop: full FIFO, ready=1 and qualifying write same edge -> count stays 4, drops unchanged.
- Clear: 3 entries, drops=5, assert `i_clear` with coincident write -> count=0, drops=0, valid=0; timestamp not reset.
- Timestamp wrap: TS_W=4, writes at cycles 14 and 17 -> ts 14 then 1.

Source files
------------

// File: rtl/mmio_write_capture_pkg.sv
// mmio_write_capture_pkg
// Shared definitions for the MMIO write monitor: default bus widths,
// drop-counter width and its saturating increment helper.
package mmio_write_capture_pkg;

    localparam int DEF_ADDR_W = 30;
    localparam int DEF_DATA_W = 32;
    localparam int DROP_W     = 16;

    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    function automatic logic [DROP_W-1:0] drop_inc(input logic [DROP_W-1:0] cur);
        return (cur == DROP_MAX) ? cur : cur + 1'b1;
    endfunction

endpackage

// File: rtl/mmio_write_capture_sync_fifo.sv
// sync_fifo
// First-word fall-through synchronous FIFO used to hold captured records.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   clear          : synchronous flush; beats push and pop
//   push, din      : write request and data (accepted when not full, or when
//                    a pop happens in the same cycle)
//   pop            : read request (ignored when empty)
//   dout           : head entry, valid while empty = 0
//   full, empty    : occupancy flags
//   count          : entries held
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    // When full, the slot freed by a same-cycle pop is the one being written.
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok && !clear) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_write_capture.sv
// mmio_write_capture
// Taps the CPU MMIO write port and records qualifying writes, with a
// timestamp and a "writes were lost before this one" flag, into a FIFO
// drained by a valid/ready reader.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   i_mmio_addr/data/mask/wren : tapped write port (word address)
//   i_en                       : capture enable
//   i_clear                    : synchronous flush of FIFO, drops and gap flag
//   o_rec_valid, i_rec_ready   : head record handshake
//   o_rec_addr/data/mask/ts/gap: head record fields
//   o_count                    : entries held
//   o_drops                    : saturating count of writes lost to a full FIFO
module mmio_write_capture
    import mmio_write_capture_pkg::*;
#(
    parameter  int                ADDR_W = DEF_ADDR_W,
    parameter  int                DATA_W = DEF_DATA_W,
    parameter  int                DEPTH  = 16,
    parameter  int                TS_W   = 16,
    parameter  logic [ADDR_W-1:0] WIN_LO = '0,
    parameter  logic [ADDR_W-1:0] WIN_HI = '1,
    localparam int                MASK_W = DATA_W / 8,
    localparam int                CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] i_mmio_addr,
    input  logic [DATA_W-1:0] i_mmio_data,
    input  logic [MASK_W-1:0] i_mmio_mask,
    input  logic              i_mmio_wren,
    input  logic              i_en,
    input  logic              i_clear,
    output logic              o_rec_valid,
    input  logic              i_rec_ready,
    output logic [ADDR_W-1:0] o_rec_addr,
    output logic [DATA_W-1:0] o_rec_data,
    output logic [MASK_W-1:0] o_rec_mask,
    output logic [TS_W-1:0]   o_rec_ts,
    output logic              o_rec_gap,
    output logic [CNT_W-1:0]  o_count,
    output logic [DROP_W-1:0] o_drops
);

    localparam int REC_W = 1 + TS_W + MASK_W + ADDR_W + DATA_W;

    logic [TS_W-1:0]   ts_q;
    logic              gap_q;
    logic [DROP_W-1:0] drops_q;
    logic [REC_W-1:0]  rec_in;
    logic [REC_W-1:0]  fifo_dout;
    logic [REC_W-1:0]  hold_q;
    logic [REC_W-1:0]  rec_out;
    logic              fifo_full;
    logic              fifo_empty;
    logic              lo_ok;
    logic              hi_ok;
    logic              qual;
    logic              pop_act;
    logic              drop;
    logic              store;

    // Open-ended window edges skip the compare, which would be constant.
    if (WIN_LO == '0) begin : g_lo_open
        assign lo_ok = 1'b1;
    end else begin : g_lo
        assign lo_ok = (i_mmio_addr >= WIN_LO);
    end

    if (WIN_HI == '1) begin : g_hi_open
        assign hi_ok = 1'b1;
    end else begin : g_hi
        assign hi_ok = (i_mmio_addr <= WIN_HI);
    end

    assign qual    = i_mmio_wren && i_en && (i_mmio_mask != '0) && lo_ok && hi_ok;
    assign pop_act = i_rec_ready && !fifo_empty;
    assign drop    = qual && !i_clear && fifo_full && !pop_act;
    assign store   = qual && !i_clear && !drop;

    assign rec_in = {gap_q, ts_q, i_mmio_mask, i_mmio_addr, i_mmio_data};

    sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (i_clear),
        .push  (qual),
        .pop   (i_rec_ready),
        .din   (rec_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (o_count)
    );

    // The FIFO head slot may hold stale data once emptied; show the last
    // presented record instead so idle outputs stay put.
    assign rec_out     = fifo_empty ? hold_q : fifo_dout;
    assign o_rec_valid = !fifo_empty;
    assign {o_rec_gap, o_rec_ts, o_rec_mask, o_rec_addr, o_rec_data} = rec_out;
    assign o_drops     = drops_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q    <= '0;
            gap_q   <= 1'b0;
            drops_q <= '0;
            hold_q  <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
            if (!fifo_empty) begin
                hold_q <= fifo_dout;
            end
            if (i_clear) begin
                gap_q   <= 1'b0;
                drops_q <= '0;
            end else if (drop) begin
                gap_q   <= 1'b1;
                drops_q <= drop_inc(drops_q);
            end else if (store) begin
                gap_q   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mmio_write_capture.sv
module tb_mmio_write_capture;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [29:0] addr = '0;
    logic [31:0] data = '0;
    logic [3:0]  mask = '0;
    logic        wren = 1'b0;
    logic        en = 1'b1;
    logic        clr = 1'b0;
    logic        ready = 1'b0;

    logic        o_rec_valid;
    logic [29:0] o_rec_addr;
    logic [31:0] o_rec_data;
    logic [3:0]  o_rec_mask;
    logic [3:0]  o_rec_ts;
    logic        o_rec_gap;
    logic [2:0]  o_count;
    logic [15:0] o_drops;

    always #5 clk = ~clk;

    mmio_write_capture #(
        .ADDR_W (30),
        .DATA_W (32),
        .DEPTH  (DEPTH),
        .TS_W   (4),
        .WIN_LO (30'h40),
        .WIN_HI (30'h4F)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_mmio_addr (addr),
        .i_mmio_data (data),
        .i_mmio_mask (mask),
        .i_mmio_wren (wren),
        .i_en        (en),
        .i_clear     (clr),
        .o_rec_valid (o_rec_valid),
        .i_rec_ready (ready),
        .o_rec_addr  (o_rec_addr),
        .o_rec_data  (o_rec_data),
        .o_rec_mask  (o_rec_mask),
        .o_rec_ts    (o_rec_ts),
        .o_rec_gap   (o_rec_gap),
        .o_count     (o_count),
        .o_drops     (o_drops)
    );

    typedef struct {
        logic [29:0] a;
        logic [31:0] d;
        logic [3:0]  m;
        int          ts;
        logic        gap;
    } rec_t;

    rec_t q[$];
    rec_t last;
    int   m_drops;
    logic m_gap;
    int   m_ts;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        last    = '{a: '0, d: '0, m: '0, ts: 0, gap: 1'b0};
        m_drops = 0;
        m_gap   = 1'b0;
        m_ts    = 0;
    endtask

    task automatic compare();
        rec_t e;
        chk("valid", 64'(o_rec_valid), 64'(q.size() > 0));
        chk("count", 64'(o_count), 64'(q.size()));
        chk("drops", 64'(o_drops), 64'(m_drops));
        if (q.size() > 0) begin
            e    = q[0];
            last = e;
        end else begin
            e = last;
        end
        chk("addr", 64'(o_rec_addr), 64'(e.a));
        chk("data", 64'(o_rec_data), 64'(e.d));
        chk("mask", 64'(o_rec_mask), 64'(e.m));
        chk("ts",   64'(o_rec_ts),   64'(e.ts));
        chk("gap",  64'(o_rec_gap),  64'(e.gap));
    endtask

    // One clock edge: model applies the rules to the inputs present at the
    // edge, then outputs are sampled 1 time unit later.
    task automatic step();
        bit qual;
        qual = wren && en && (mask != 4'h0) && (addr >= 30'h40) && (addr <= 30'h4F);
        @(posedge clk);
        if (clr) begin
            q.delete();
            m_drops = 0;
            m_gap   = 1'b0;
        end else begin
            if (q.size() > 0 && ready) void'(q.pop_front());
            if (qual) begin
                if (q.size() < DEPTH) begin
                    q.push_back('{a: addr, d: data, m: mask, ts: m_ts, gap: m_gap});
                    m_gap = 1'b0;
                end else begin
                    if (m_drops < 65535) m_drops++;
                    m_gap = 1'b1;
                end
            end
        end
        m_ts = (m_ts + 1) % 16;
        #1;
        compare();
    endtask

    task automatic wr(input logic [29:0] a, input logic [31:0] d, input logic [3:0] m,
                      input logic rdy);
        addr  = a;
        data  = d;
        mask  = m;
        wren  = 1'b1;
        ready = rdy;
        step();
        wren  = 1'b0;
    endtask

    task automatic idle(input logic rdy);
        wren  = 1'b0;
        ready = rdy;
        step();
    endtask

    initial begin
        model_reset();
        // reset: all outputs zero
        repeat (3) @(posedge clk);
        #1;
        compare();
        rst_n = 1'b1;
        m_ts  = 0;

        // first capture: edges 0..2 idle, write at edge 3
        repeat (3) idle(1'b0);
        wr(30'h44, 32'hDEADBEEF, 4'hF, 1'b0);
        chk("rst_data", 64'(o_rec_data), 64'h0000_0000_DEAD_BEEF);
        chk("rst_ts", 64'(o_rec_ts), 64'd3);
        chk("rst_gap", 64'(o_rec_gap), 64'd0);
        idle(1'b1);

        // address window and mask filter
        wr(30'h3F, 32'h11, 4'h1, 1'b0);
        wr(30'h40, 32'h22, 4'h3, 1'b0);
        wr(30'h4F, 32'h33, 4'h8, 1'b0);
        wr(30'h50, 32'h44, 4'hF, 1'b0);
        wr(30'h41, 32'h55, 4'h0, 1'b0);
        chk("filt_count", 64'(o_count), 64'd2);
        chk("filt_drops", 64'(o_drops), 64'd0);
        chk("filt_head", 64'(o_rec_addr), 64'h40);
        repeat (2) idle(1'b1);

        // overflow and gap marking
        for (int i = 1; i <= 6; i++) wr(30'h42, 32'(i), 4'hF, 1'b0);
        chk("ovf_count", 64'(o_count), 64'd4);
        chk("ovf_drops", 64'(o_drops), 64'd2);
        repeat (4) idle(1'b1);
        wr(30'h42, 32'd7, 4'hF, 1'b0);
        chk("ovf_gap7", 64'(o_rec_gap), 64'd1);
        chk("ovf_data7", 64'(o_rec_data), 64'd7);

        // full FIFO with coincident pop and write
        for (int i = 8; i <= 10; i++) wr(30'h43, 32'(i), 4'h5, 1'b0);
        wr(30'h43, 32'd11, 4'h5, 1'b1);
        chk("fullpop_count", 64'(o_count), 64'd4);
        chk("fullpop_drops", 64'(o_drops), 64'd2);

        // clear with coincident write
        for (int i = 12; i <= 14; i++) wr(30'h45, 32'(i), 4'hF, 1'b0);
        idle(1'b1);
        chk("pre_clr_count", 64'(o_count), 64'd3);
        chk("pre_clr_drops", 64'(o_drops), 64'd5);
        clr = 1'b1;
        wr(30'h46, 32'd15, 4'hF, 1'b1);
        clr = 1'b0;
        chk("clr_count", 64'(o_count), 64'd0);
        chk("clr_drops", 64'(o_drops), 64'd0);
        chk("clr_valid", 64'(o_rec_valid), 64'd0);
        wr(30'h47, 32'd16, 4'hF, 1'b0);

        // reset mid-operation discards everything at once
        rst_n = 1'b0;
        #1;
        model_reset();
        compare();
        @(posedge clk);
        #1;
        compare();
        rst_n = 1'b1;
        m_ts  = 0;

        // timestamp wrap with a 4-bit counter
        repeat (14) idle(1'b0);
        wr(30'h48, 32'hA, 4'hF, 1'b0);
        repeat (2) idle(1'b0);
        wr(30'h48, 32'hB, 4'hF, 1'b0);
        chk("wrap_ts14", 64'(o_rec_ts), 64'd14);
        idle(1'b1);
        chk("wrap_ts1", 64'(o_rec_ts), 64'd1);
        idle(1'b1);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            addr  = 30'h3C + 30'($urandom_range(0, 23));
            data  = $urandom;
            mask  = 4'($urandom_range(0, 15));
            wren  = ($urandom_range(0, 3) != 0);
            en    = ($urandom_range(0, 7) != 0);
            ready = ($urandom_range(0, 2) == 0);
            clr   = ($urandom_range(0, 40) == 0);
            step();
        end
        wren = 1'b0;
        clr  = 1'b0;
        en   = 1'b1;
        repeat (6) idle(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
